fetch_queue_unit: RTL and testbench

- Consumer side of the PC path. Takes the fetch address produced each cycle by the PC control logic and issues in-order reads to instruction memory.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- Flushes the queue and discards in-flight responses on a taken-jump redirect.
- Sits between the PC register and the decode stage of the pipelined RSA CPU.

---
 rtl/rsa_cpu_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/fetch_queue_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_cpu_pkg.sv
// Shared types and constants for the RSA CPU fetch path.
package rsa_cpu_pkg;

    // Fetch-queue controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Instruction presented to decode when the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Control-transfer opcodes whose resolution produces a redirect.
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JEQ = 4'b1101;
    localparam logic [3:0] OP_JNE = 4'b1110;

    // True for any opcode that can redirect the fetch stream.
    function automatic logic is_jump_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JEQ) || (op == OP_JNE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head output that is
// driven only from storage flops (zero when empty).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    // A pop on empty is ignored; a push while full is only legal alongside a pop.
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);

    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer/occupancy; flush empties the FIFO and overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch queue: issues in-order instruction-memory reads at the PC register's
// address, buffers returned words with their PCs, and feeds decode. A taken
// jump flushes the queue and discards responses still in flight.
module fetch_queue_unit #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] pc_addr,
    input  logic          redirect,
    output logic          pc_hold,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          dec_ready,
    output logic          busy
);

    import rsa_cpu_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

    fetch_state_t     state_q, state_d;
    logic [OW-1:0]    discard_q, discard_d;
    logic [OW-1:0]    outstanding, out_net;
    logic [CW-1:0]    q_count;
    logic [CW:0]      credit_used;
    logic [AW-1:0]    fl_head_pc;
    logic [AW+DW-1:0] q_head;
    logic             resp, redirect_eff, resp_drop, q_push, q_pop, accept;

    // A response is only real while something is outstanding; a stray
    // rvalid (e.g. a late beat after reset) is ignored.
    assign resp         = imem_rvalid && (outstanding != '0);
    // Redirects during FLUSH are already covered by the flush in progress.
    assign redirect_eff = redirect && (state_q != FLUSH);
    // Responses are dropped while discards are pending and on the redirect
    // cycle itself (that response belongs to the abandoned path).
    assign resp_drop    = resp && (redirect_eff || (discard_q != '0));
    assign q_push       = resp && !resp_drop;
    assign q_pop        = instr_valid && dec_ready;
    assign out_net      = outstanding - OW'(resp);

    // Credit rule: queued plus in-flight never exceeds the queue depth, so a
    // response always has a slot waiting for it.
    assign credit_used  = {1'b0, q_count} + (CW+1)'(outstanding);
    assign imem_req     = (state_q == FETCH) && !redirect
                          && (outstanding < MAX_OUT_C) && (credit_used < DEPTH_C);
    assign imem_addr    = pc_addr;
    assign accept       = imem_req && imem_gnt;
    assign pc_hold      = !accept;

    assign busy         = (outstanding != '0) || (discard_q != '0);
    assign instr_valid  = (q_count != '0);
    assign instr_pc     = q_head[AW+DW-1:DW];
    assign instr        = instr_valid ? q_head[DW-1:0] : DW'(NOP_INSTR);

    // PCs of accepted requests, matched in order against returning data.
    sync_fifo #(
        .WIDTH (AW),
        .DEPTH (MAX_OUT)
    ) u_inflight (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (accept),
        .pop_i   (resp),
        .flush_i (1'b0),
        .wdata_i (pc_addr),
        .head_o  (fl_head_pc),
        .count_o (outstanding)
    );

    // Decoded-ready instruction queue of {pc, instruction}.
    sync_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_iqueue (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_eff),
        .wdata_i ({fl_head_pc, imem_rdata}),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Discard counter: a redirect marks everything still in flight after this
    // cycle's response as stale; each dropped response retires one.
    always_comb begin
        discard_d = discard_q;
        if (redirect_eff) begin
            discard_d = out_net;
        end else if (resp_drop) begin
            discard_d = discard_q - OW'(1);
        end
    end

    // Next-state logic for the fetch controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (redirect && (out_net != '0)) state_d = FLUSH;
                else if (!start)                 state_d = DRAIN;
            end
            FLUSH: begin
                if (discard_d == '0) state_d = start ? FETCH : IDLE;
            end
            DRAIN: begin
                if (out_net == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and discard count, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit with an in-order memory model and a
// queue-based reference of the fetch/flush/discard rules.
module tb_fetch_queue_unit;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc_addr = '0;
    logic          redirect = 1'b0;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          dec_ready = 1'b0;
    logic          pc_hold, imem_req, instr_valid, busy;
    logic [AW-1:0] imem_addr, instr_pc;
    logic [DW-1:0] instr;

    fetch_queue_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_addr(pc_addr),
        .redirect(redirect), .pc_hold(pc_hold), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .dec_ready(dec_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: queued {pc,instr}, in-flight PCs, discard count, mode.
    logic [63:0]   m_q[$];
    logic [AW-1:0] m_fl[$];
    int            m_disc = 0;
    int            m_mode = M_IDLE;

    // Environment: memory response schedule, PC register, knobs, logs.
    logic [AW-1:0] mem_a[$];
    int            mem_due[$];
    int            cyc = 0;
    int            last_due = 0;
    logic [AW-1:0] pc_next = '0;
    int            k_start = 0, k_rdy = 0, k_gnt = 0, k_lat_lo = 1, k_lat_hi = 1, k_redir = 0;
    logic          force_redir = 1'b0;
    logic [AW-1:0] force_tgt = '0;
    logic [AW-1:0] acc_log[$];
    logic [63:0]   deq_log[$];
    int            hold_cnt = 0;
    int            max_out = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive after the edge, compare at the falling edge, then
    // advance the environment and the reference model.
    task automatic cycle();
        logic          exp_req, resp, redir_eff;
        logic [AW-1:0] tgt, pc;
        int            net, lat, due;
        @(posedge clk);
        #1;
        cyc++;
        pc_addr   = pc_next;
        start     = ($urandom_range(0, 99) < k_start);
        dec_ready = ($urandom_range(0, 99) < k_rdy);
        imem_gnt  = ($urandom_range(0, 99) < k_gnt);
        redirect  = force_redir || ($urandom_range(0, 999) < k_redir);
        tgt       = force_redir ? force_tgt : (AW'($urandom_range(0, 255)) << 2);
        if (mem_a.size() != 0 && mem_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_a[0]);
            void'(mem_a.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        @(negedge clk);
        exp_req = (m_mode == M_FETCH) && !redirect && (m_fl.size() < MAX_OUT)
                  && (m_q.size() + m_fl.size() < DEPTH);
        chk("imem_req", imem_req, exp_req);
        chk("pc_hold", pc_hold, !(exp_req && imem_gnt));
        chk("imem_addr", imem_addr, pc_addr);
        chk("instr_valid", instr_valid, m_q.size() != 0);
        chk("instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
        chk("instr", instr, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
        chk("busy", busy, (m_fl.size() != 0) || (m_disc != 0));
        // memory accepts the DUT's request and schedules an in-order reply
        if (imem_req && imem_gnt) begin
            acc_log.push_back(imem_addr);
            lat = $urandom_range(k_lat_lo, k_lat_hi);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_a.push_back(imem_addr);
            mem_due.push_back(due);
        end
        if (mem_a.size() > max_out) max_out = mem_a.size();
        if (instr_valid && dec_ready) deq_log.push_back({instr_pc, instr});
        if (pc_hold) hold_cnt++;
        if (redirect)      pc_next = tgt;
        else if (!pc_hold) pc_next = pc_addr + 32'd4;
        // reference model update
        resp      = imem_rvalid && (m_fl.size() != 0);
        redir_eff = redirect && (m_mode != M_FLUSH);
        if (m_q.size() != 0 && dec_ready) void'(m_q.pop_front());
        if (resp) begin
            pc = m_fl.pop_front();
            if (redir_eff || m_disc > 0) begin
                if (!redir_eff) m_disc--;
            end else begin
                m_q.push_back({pc, imem_rdata});
            end
        end
        if (redir_eff) begin
            m_q.delete();
            m_disc = m_fl.size();
        end
        net = m_fl.size();
        if (exp_req && imem_gnt) m_fl.push_back(pc_addr);
        case (m_mode)
            M_IDLE:  if (start) m_mode = M_FETCH;
            M_FETCH: begin
                if (redirect && net > 0) m_mode = M_FLUSH;
                else if (!start)         m_mode = M_DRAIN;
            end
            M_FLUSH: if (m_disc == 0) m_mode = start ? M_FETCH : M_IDLE;
            default: if (m_fl.size() == 0) m_mode = M_IDLE;
        endcase
    endtask

    // Asynchronous reset pulse between clock edges; memory keeps its
    // pending replies so they arrive late.
    task automatic async_reset();
        #1;
        reset = 1'b0; start = 1'b0; redirect = 1'b0;
        imem_rvalid = 1'b0; dec_ready = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_hold", pc_hold, 1);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        m_q.delete(); m_fl.delete(); m_disc = 0; m_mode = M_IDLE;
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_mem_empty();
        k_start = 0;
        for (int i = 0; i < 60 && mem_a.size() != 0; i++) cycle();
        chk("mem_drained", mem_a.size(), 0);
    endtask

    initial begin
        async_reset();

        // straight-line fetch, latency 1, decode always ready
        k_start = 100; k_rdy = 100; k_gnt = 100; k_lat_lo = 1; k_lat_hi = 1;
        pc_next = '0;
        acc_log.delete(); deq_log.delete();
        cycle();
        hold_cnt = 0;
        repeat (9) cycle();
        chk("A_hold_cycles", hold_cnt, 0);
        chk("A_acc_n", acc_log.size() >= 3, 1);
        chk("A_addr0", acc_log[0], 32'h0);
        chk("A_addr1", acc_log[1], 32'h4);
        chk("A_addr2", acc_log[2], 32'h8);
        chk("A_deq_n", deq_log.size() >= 3, 1);
        chk("A_pc0", deq_log[0][63:32], 32'h0);
        chk("A_data0", deq_log[0][31:0], 32'h5A5A0F0F);
        chk("A_pc1", deq_log[1][63:32], 32'h4);
        chk("A_data1", deq_log[1][31:0], mem_word(32'h4));
        chk("A_pc2", deq_log[2][63:32], 32'h8);

        // drain to idle, then fill with decode stalled
        k_start = 0;
        repeat (8) cycle();
        chk("drained_valid", instr_valid, 0);
        k_start = 100; k_rdy = 0;
        acc_log.delete();
        repeat (12) cycle();
        chk("B_req_count", acc_log.size(), 4);
        chk("B_req_low", imem_req, 0);
        chk("B_hold_high", pc_hold, 1);
        k_rdy = 100;
        repeat (6) cycle();

        // long latency: outstanding bounded by MAX_OUT
        k_start = 0;
        repeat (10) cycle();
        k_start = 100; k_lat_lo = 5; k_lat_hi = 5; max_out = 0;
        repeat (30) cycle();
        chk("C_max_out", max_out, 2);

        // redirect to 0x40 with work queued and in flight
        k_rdy = 0;
        repeat (8) cycle();
        force_redir = 1'b1; force_tgt = 32'h40;
        cycle();
        force_redir = 1'b0;
        cycle();
        chk("D_valid_after_redirect", instr_valid, 0);
        k_rdy = 100;
        deq_log.delete();
        for (int i = 0; i < 40 && deq_log.size() == 0; i++) cycle();
        chk("D_first_pc", (deq_log.size() != 0) ? deq_log[0][63:32] : 32'hFFFFFFFF, 32'h40);

        // reset while requests are in flight; late replies must be ignored
        repeat (3) cycle();
        async_reset();
        k_start = 0;
        repeat (12) cycle();
        chk("E_busy", busy, 0);
        chk("E_valid", instr_valid, 0);
        wait_mem_empty();

        // randomised traffic with redirects, stalls and one reset
        k_start = 97; k_rdy = 60; k_gnt = 70; k_lat_lo = 1; k_lat_hi = 6; k_redir = 40;
        repeat (1500) cycle();
        async_reset();
        wait_mem_empty();
        k_start = 97;
        repeat (1500) cycle();
        k_redir = 0; k_start = 0;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
